// File: rtl/aes_spi_sequencer.sv
// -----------------------------------------------------------------------------
// aes_spi_sequencer
//
// Runs one complete AES block operation over the SPI link to the Cipher slave:
// 8 key words, 8 data words, then 9 readback words. The first readback word is
// the slave's stale shift register, so it ends up shifted out of the result.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   start             begin an operation (sampled only while idle)
//   mode              1 = decrypt, 0 = encrypt (latched at start)
//   key, block_in     128-bit key and data block (latched at start)
//   busy              high while transfers are being sequenced
//   done              one-cycle pulse at the end (success or timeout)
//   error             set with done on timeout, held until next accepted start
//   result            128-bit result, valid from done until next accepted start
//   cipher_mode       latched mode, drives the Cipher MODE pin
//   spi_data_in       word to SPI_MASTER DATA_IN
//   spi_data_valid    transfer request to SPI_MASTER
//   spi_cs            SPI_MASTER CS (low = transfer in progress)
//   spi_done          SPI_MASTER DONE pulse, one per completed transfer
//   spi_data_out      SPI_MASTER DATA_OUT, valid with spi_done
// -----------------------------------------------------------------------------
module aes_spi_sequencer #(
    parameter int WORD_W  = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [127:0]      key,
    input  logic [127:0]      block_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [127:0]      result,
    output logic              cipher_mode,
    output logic [WORD_W-1:0] spi_data_in,
    output logic              spi_data_valid,
    input  logic              spi_cs,
    input  logic              spi_done,
    input  logic [WORD_W-1:0] spi_data_out
);

    localparam int NWORDS = 128 / WORD_W;
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_KEY_REQ,
        S_KEY_WAIT,
        S_TEXT_REQ,
        S_TEXT_WAIT,
        S_RECV_REQ,
        S_RECV_WAIT,
        S_FIN,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [127:0]      sh_q,    sh_d;     // outgoing word shifter, LS word first
    logic [127:0]      blk_q,   blk_d;    // data block waiting for the TEXT phase
    logic [127:0]      res_q,   res_d;
    logic [3:0]        idx_q,   idx_d;
    logic [WD_W-1:0]   wd_q,    wd_d;     // watchdog, cycles spent on this word
    logic              err_q,   err_d;
    logic              mode_q,  mode_d;

    logic   in_key, in_text, in_recv, in_req, in_xfer;
    logic   [3:0] last_idx;
    state_e req_st, wait_st;

    always_comb begin
        in_key   = (state_q == S_KEY_REQ)  || (state_q == S_KEY_WAIT);
        in_text  = (state_q == S_TEXT_REQ) || (state_q == S_TEXT_WAIT);
        in_recv  = (state_q == S_RECV_REQ) || (state_q == S_RECV_WAIT);
        in_req   = (state_q == S_KEY_REQ)  || (state_q == S_TEXT_REQ) ||
                   (state_q == S_RECV_REQ);
        in_xfer  = in_key || in_text || in_recv;
        // Readback needs one extra transfer to flush the slave's stale word.
        last_idx = in_recv ? 4'(NWORDS) : 4'(NWORDS - 1);
        if (in_key) begin
            req_st  = S_KEY_REQ;
            wait_st = S_KEY_WAIT;
        end else if (in_text) begin
            req_st  = S_TEXT_REQ;
            wait_st = S_TEXT_WAIT;
        end else begin
            req_st  = S_RECV_REQ;
            wait_st = S_RECV_WAIT;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        blk_d   = blk_q;
        res_d   = res_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        err_d   = err_q;
        mode_d  = mode_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sh_d    = key;
                    blk_d   = block_in;
                    mode_d  = mode;
                    res_d   = '0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    wd_d    = '0;
                    state_d = S_KEY_REQ;
                end
            end

            S_KEY_REQ, S_KEY_WAIT, S_TEXT_REQ, S_TEXT_WAIT,
            S_RECV_REQ, S_RECV_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                // A completion wins over both the watchdog and the CS handshake;
                // a DONE that arrives while still in REQ counts for this word.
                if (spi_done) begin
                    wd_d  = '0;
                    idx_d = idx_q + 4'd1;
                    sh_d  = sh_q >> WORD_W;
                    if (in_recv)
                        res_d = {spi_data_out, res_q[127:WORD_W]};
                    if (idx_q == last_idx) begin
                        idx_d = '0;
                        if (in_key) begin
                            state_d = S_TEXT_REQ;
                            sh_d    = blk_q;
                        end else if (in_text) begin
                            state_d = S_RECV_REQ;
                        end else begin
                            state_d = S_FIN;
                        end
                    end else begin
                        state_d = req_st;
                    end
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (in_req && !spi_cs) begin
                    state_d = wait_st;
                end
            end

            S_FIN, S_ERR: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            blk_q   <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            blk_q   <= blk_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            mode_q  <= mode_d;
        end
    end

    // busy falls on the same edge that enters FIN/ERR, where done rises.
    assign busy           = in_xfer;
    assign done           = (state_q == S_FIN) || (state_q == S_ERR);
    assign error          = err_q;
    assign result         = res_q;
    assign cipher_mode    = mode_q;
    // Readback words carry no payload; the shifter is held in WAIT so the
    // word stays on the bus for the whole transfer.
    assign spi_data_in    = (in_key || in_text) ? sh_q[WORD_W-1:0] : '0;
    // Gated by rst so a reset drops the request without waiting for the edge.
    assign spi_data_valid = in_req && !rst;

endmodule

// File: tb/tb_aes_spi_sequencer.sv
module tb_aes_spi_sequencer;

    localparam int TO = 32;

    logic         clk = 1'b0;
    logic         rst, start, mode;
    logic [127:0] key, block_in;
    logic         busy, done, error, cipher_mode;
    logic [127:0] result;
    logic [15:0]  spi_data_in;
    logic         spi_data_valid;
    logic         spi_cs, spi_done;
    logic [15:0]  spi_data_out;

    aes_spi_sequencer #(.WORD_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key),
        .block_in(block_in), .busy(busy), .done(done), .error(error),
        .result(result), .cipher_mode(cipher_mode), .spi_data_in(spi_data_in),
        .spi_data_valid(spi_data_valid), .spi_cs(spi_cs), .spi_done(spi_done),
        .spi_data_out(spi_data_out)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ncmp = 0, nfail = 0;

    // Written by main only
    logic [15:0] rep_arr [9];
    int          op_base;
    int          stall_at;
    int          abort_cnt;
    // Written by the SPI model only
    logic [15:0] logq [$];
    bit          gapq [$];
    int          xfer_idx = 0;
    int          cap_cyc = 0;

    // SPI_MASTER + Cipher stand-in: random CS lag and transfer length, logs
    // every word requested, answers readbacks from rep_arr.
    initial begin : spi_model
        int cnt, lag, cur, rel, seen_ab;
        bit active, chk_gap;
        active = 0; chk_gap = 0; cnt = 0; lag = 0; cur = 0; seen_ab = 0;
        spi_cs = 1'b1; spi_done = 1'b0; spi_data_out = '0;
        forever begin
            @(negedge clk);
            spi_done = 1'b0;
            if (chk_gap) begin
                gapq.push_back(spi_data_valid);
                chk_gap = 0;
            end
            if (rst || abort_cnt != seen_ab) begin
                seen_ab = abort_cnt;
                active  = 0;
                spi_cs  = 1'b1;
            end else if (!active) begin
                if (spi_data_valid) begin
                    logq.push_back(spi_data_in);
                    if (xfer_idx == stall_at) cap_cyc = cyc;
                    cur = xfer_idx;
                    xfer_idx++;
                    active = 1;
                    cnt = $urandom_range(1, 8);
                    lag = $urandom_range(0, 2);
                end
            end else begin
                if (lag > 0) lag--; else spi_cs = 1'b0;
                if (cur != stall_at) begin
                    if (cnt > 0) cnt--;
                    else begin
                        rel = cur - op_base;
                        spi_data_out = (rel >= 16 && rel < 25) ? rep_arr[rel-16]
                                                               : 16'($urandom);
                        spi_done = 1'b1;
                        spi_cs   = 1'b1;
                        active   = 0;
                        chk_gap  = 1;
                    end
                end
            end
        end
    end

    initial begin : global_bound
        #400000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] k, input logic [127:0] b, input logic m);
        key = k; block_in = b; mode = m; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    // Reference: the words the slave must see for one operation
    function automatic logic [15:0] exp_word(input logic [127:0] k, input logic [127:0] b,
                                             input int i);
        if (i < 8)       return k[16*i +: 16];
        else if (i < 16) return b[16*(i-8) +: 16];
        else             return 16'h0000;
    endfunction

    // Reference: readback 0 is discarded, readbacks 1..8 fill LS to MS
    function automatic logic [127:0] exp_res(input logic [15:0] r [9]);
        logic [127:0] v;
        v = '0;
        for (int j = 1; j < 9; j++) v[16*(j-1) +: 16] = r[j];
        return v;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic run_full(input string tag, input logic [127:0] k, input logic [127:0] b,
                            input logic m, input logic [15:0] r [9], input bit mid,
                            output int lb);
        int gb, ones;
        bit ok;
        logic [127:0] er;
        logic [15:0] obs;
        lb = logq.size();
        gb = gapq.size();
        op_base = xfer_idx;
        for (int i = 0; i < 9; i++) rep_arr[i] = r[i];
        do_start(k, b, m);
        chk({tag, "/acc_busy"},  busy, 1);
        chk({tag, "/acc_valid"}, spi_data_valid, 1);
        chk({tag, "/acc_word0"}, spi_data_in, k[15:0]);
        chk({tag, "/acc_err"},   error, 0);
        if (mid) begin
            ok = 0;
            for (int i = 0; i < 2000; i++) begin
                if (xfer_idx - op_base >= 10) begin ok = 1; break; end
                tick();
            end
            chk({tag, "/reach_text"}, ok, 1);
            do_start(~k, ~b, ~m);
        end
        wait_done(ok);
        chk({tag, "/done_seen"}, ok, 1);
        er = exp_res(r);
        chk({tag, "/result"}, result, er);
        chk({tag, "/error"},  error, 0);
        chk({tag, "/busy_at_done"}, busy, 0);
        chk({tag, "/cmode"},  cipher_mode, m);
        chk({tag, "/nxfer"},  logq.size() - lb, 25);
        for (int i = 0; i < 25; i++) begin
            obs = (lb + i < logq.size()) ? logq[lb+i] : 16'hxxxx;
            chk($sformatf("%s/word%0d", tag, i), obs, exp_word(k, b, i));
        end
        tick();
        chk({tag, "/done_pulse"}, done, 0);
        chk({tag, "/result_hold"}, result, er);
        ones = 0;
        for (int i = gb; i < gapq.size(); i++) ones += int'(gapq[i]);
        chk({tag, "/ngaps"}, gapq.size() - gb, 25);
        chk({tag, "/back_to_back"}, ones, 24);
    endtask

    initial begin : main
        logic [15:0]  rr [9];
        logic [127:0] k, b, pt;
        int lb;
        bit ok;
        rst = 1'b1; start = 1'b0; mode = 1'b0; key = '0; block_in = '0;
        stall_at = -1; abort_cnt = 0; op_base = 0;
        for (int i = 0; i < 9; i++) rep_arr[i] = '0;
        repeat (3) tick();
        chk("rst/busy", busy, 0);
        chk("rst/done", done, 0);
        chk("rst/error", error, 0);
        chk("rst/valid", spi_data_valid, 0);
        chk("rst/cmode", cipher_mode, 0);
        chk("rst/data_in", spi_data_in, 0);
        chk("rst/result", result, 0);
        rst = 1'b0;
        tick();

        // FIPS-197 vector, decrypt direction
        k  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        b  = 128'h3925841d02dc09fbdc118597196a0b32;
        pt = 128'h3243f6a8885a308d313198a2e0370734;
        rr[0] = 16'h5a5a;
        for (int j = 1; j < 9; j++) rr[j] = pt[16*(j-1) +: 16];
        run_full("dec", k, b, 1'b1, rr, 1'b0, lb);
        chk("dec/result_lit", result, 128'h3243f6a8885a308d313198a2e0370734);
        chk("dec/w0",  logq[lb+0],  16'h4f3c);
        chk("dec/w1",  logq[lb+1],  16'h09cf);
        chk("dec/w2",  logq[lb+2],  16'h1588);
        chk("dec/w7",  logq[lb+7],  16'h2b7e);
        chk("dec/w8",  logq[lb+8],  16'h0b32);
        chk("dec/w9",  logq[lb+9],  16'h196a);
        chk("dec/w15", logq[lb+15], 16'h3925);
        chk("dec/w24", logq[lb+24], 16'h0000);

        // Readback alignment: stale word must not appear
        rr[0] = 16'haaaa;
        for (int j = 1; j < 9; j++) rr[j] = 16'(j);
        run_full("align", rand128(), rand128(), 1'b0, rr, 1'b0, lb);
        chk("align/result_lit", result, 128'h0008000700060005000400030002_0001);

        // Random operations
        for (int t = 0; t < 3; t++) begin
            for (int j = 0; j < 9; j++) rr[j] = 16'($urandom);
            run_full($sformatf("rnd%0d", t), rand128(), rand128(), 1'($urandom), rr, 1'b0, lb);
        end

        // Watchdog: third key word never completes
        lb = logq.size();
        stall_at = xfer_idx + 2;
        do_start(rand128(), rand128(), 1'b0);
        wait_done(ok);
        chk("to/done_seen", ok, 1);
        chk("to/error", error, 1);
        chk("to/valid", spi_data_valid, 0);
        chk("to/busy", busy, 0);
        chk("to/result", result, 0);
        chk("to/latency", cyc - cap_cyc, TO);
        chk("to/nxfer", logq.size() - lb, 3);
        tick();
        chk("to/done_pulse", done, 0);
        chk("to/error_hold", error, 1);
        stall_at = -1;
        abort_cnt++;
        tick();
        tick();

        // start mid-TEXT is ignored; the accepted start also clears error
        for (int j = 0; j < 9; j++) rr[j] = 16'($urandom);
        run_full("mid", rand128(), rand128(), 1'b1, rr, 1'b1, lb);

        // Reset during RECV
        for (int j = 0; j < 9; j++) rep_arr[j] = 16'($urandom) | 16'h0001;
        op_base = xfer_idx;
        do_start(rand128(), rand128(), 1'b1);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (xfer_idx - op_base >= 18) begin ok = 1; break; end
            tick();
        end
        chk("rstm/reach_recv", ok, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rstm/valid_immediate", spi_data_valid, 0);
        @(posedge clk);
        #1;
        chk("rstm/busy", busy, 0);
        chk("rstm/valid", spi_data_valid, 0);
        chk("rstm/result", result, 0);
        chk("rstm/done", done, 0);
        chk("rstm/cmode", cipher_mode, 0);
        chk("rstm/data_in", spi_data_in, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        for (int j = 0; j < 9; j++) rr[j] = 16'($urandom);
        run_full("post_rst", rand128(), rand128(), 1'b0, rr, 1'b0, lb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
